// File: rtl/ram_burst_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package   : ram_burst_pkg                                                |
// | Purpose   : Shared state encodings and skid-buffer sizing for the RAM    |
// |             burst master and its read-return skid buffer.                |
// | Contents  : ST_* FSM state codes, SKID_DEPTH, SKID_CNT_W                 |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
package ram_burst_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_WRITE = 2'd1;
  localparam state_t ST_READ  = 2'd2;
  localparam state_t ST_DRAIN = 2'd3;

  // Read-return buffer depth; also the number of read credits.
  localparam int SKID_DEPTH = 2;
  localparam int SKID_CNT_W = $clog2(SKID_DEPTH + 1);

endpackage
`default_nettype wire

// File: rtl/ram_rd_skid.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : ram_rd_skid                                                  |
// | Purpose   : Small FIFO catching RAM read data one cycle after issue and  |
// |             presenting it to the read stream.                            |
// | Ports     : clk, reset (sync, active-high)                               |
// |             push/din   - write side (RAM dout lands here)                 |
// |             pop/dout   - read side (head entry)                          |
// |             count/full/empty - occupancy status                          |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
module ram_rd_skid
  import ram_burst_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic [SKID_CNT_W-1:0] count,
  output logic                  full,
  output logic                  empty
);

  localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;

  logic [WIDTH-1:0]      r_mem [SKID_DEPTH];
  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [SKID_CNT_W-1:0] r_count;
  logic                  w_push;
  logic                  w_pop;

  assign full   = (r_count == SKID_CNT_W'(SKID_DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign dout   = r_mem[r_rptr];

  // Guard against overflow/underflow even though the credit scheme upstream
  // never pushes into a full buffer.
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + SKID_CNT_W'(1);
        2'b01:   r_count <= r_count - SKID_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Data storage needs no reset; validity is tracked by r_count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/ram_burst_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : ram_burst_master                                             |
// | Purpose   : Burst initiator for a single-port synchronous RAM with       |
// |             1-cycle read latency. Streams write beats into the RAM or    |
// |             read beats out of it, one beat per cycle sustained.          |
// | Ports     : clk, reset (sync, active-high)                               |
// |             cmd_*  - burst command (valid/ready, write, addr, len)       |
// |             wr_*   - write data stream (valid/ready/data)                |
// |             rd_*   - read data stream (valid/ready/data)                 |
// |             busy, done - status (done pulses once per burst)             |
// |             ram_*  - RAM port (we/addr/din out, dout in)                 |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
module ram_burst_master
  import ram_burst_pkg::*;
#(
  parameter int DATAWID  = 8,
  parameter int ADDERWID = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDERWID-1:0] cmd_addr,
  input  logic [ADDERWID-1:0] cmd_len,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [DATAWID-1:0]  wr_data,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [DATAWID-1:0]  rd_data,
  output logic                busy,
  output logic                done,
  output logic                ram_we,
  output logic [ADDERWID-1:0] ram_addr,
  output logic [DATAWID-1:0]  ram_din,
  input  logic [DATAWID-1:0]  ram_dout
);

  localparam int OCC_W = SKID_CNT_W + 1;

  state_t                r_state;
  logic [ADDERWID-1:0]   r_addr;
  logic [ADDERWID-1:0]   r_remaining;
  logic                  r_inflight;
  logic                  r_done;

  logic [SKID_CNT_W-1:0] w_count;
  logic                  w_full;
  logic                  w_empty;
  logic [DATAWID-1:0]    w_skid_dout;
  logic                  w_last;
  logic                  w_wr_beat;
  logic                  w_pop;
  logic [OCC_W-1:0]      w_occ_after;
  logic                  w_issue;
  logic                  w_drain_done;

  assign w_last    = (r_remaining == '0);
  assign w_wr_beat = (r_state == ST_WRITE) && wr_valid;
  assign w_pop     = !w_empty && rd_ready;

  // Every issued read needs a skid slot when it lands next cycle. Entries
  // held plus the one in flight, minus the one leaving now, must leave room.
  assign w_occ_after = OCC_W'(w_count) + OCC_W'(r_inflight) - OCC_W'(w_pop);
  assign w_issue     = (r_state == ST_READ) && !(w_full && !w_pop) &&
                       (w_occ_after < OCC_W'(SKID_DEPTH));

  // The burst is finished only when the final entry leaves and nothing
  // remains in flight behind it.
  assign w_drain_done = (r_state == ST_DRAIN) && w_pop && !r_inflight &&
                        (w_count == SKID_CNT_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_inflight  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_inflight <= w_issue;
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_addr      <= cmd_addr;
            r_remaining <= cmd_len;
            r_state     <= cmd_write ? ST_WRITE : ST_READ;
          end
        end
        ST_WRITE: begin
          if (wr_valid) begin
            r_addr      <= r_addr + ADDERWID'(1);
            r_remaining <= r_remaining - ADDERWID'(1);
            if (w_last) begin
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
            end
          end
        end
        ST_READ: begin
          if (w_issue) begin
            r_addr      <= r_addr + ADDERWID'(1);
            r_remaining <= r_remaining - ADDERWID'(1);
            if (w_last) r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_drain_done) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // RAM data returns one cycle after issue, exactly when r_inflight is set.
  ram_rd_skid #(
    .WIDTH (DATAWID)
  ) u_skid (
    .clk   (clk),
    .reset (reset),
    .push  (r_inflight),
    .pop   (w_pop),
    .din   (ram_dout),
    .dout  (w_skid_dout),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  assign cmd_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign wr_ready  = (r_state == ST_WRITE);
  assign done      = r_done;
  assign rd_valid  = !w_empty;
  assign rd_data   = w_skid_dout;
  assign ram_we    = w_wr_beat;
  assign ram_addr  = r_addr;
  assign ram_din   = wr_data;

endmodule
`default_nettype wire
